// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: controller states and
// default geometry used by the top level and the replacement sub-module.
package cache_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_WAYS       = 2;
    localparam int DEF_SETS       = 64;
    localparam int DEF_WORDS      = 8;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        FILL,
        WRITE_MEM
    } state_e;

endpackage

// File: rtl/cache_way_lru.sv
// Age-based replacement for one set: picks a victim way and computes the
// ages that result from touching the hit way.
module cache_way_lru
    import cache_pkg::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS*WAY_W-1:0] ages_i,
    input  logic [WAYS-1:0]       valid_i,
    input  logic [WAY_W-1:0]      hit_way_i,
    output logic [WAY_W-1:0]      victim_o,
    output logic [WAYS*WAY_W-1:0] ages_next_o
);

    logic             found;
    logic [WAY_W-1:0] old_age;
    logic [WAY_W-1:0] age_w;

    // Prefer the lowest-index empty way; otherwise evict the oldest one.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        victim_o = '0;
        found    = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!found && !valid_i[i]) begin
                victim_o = WAY_W'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            if (!found && ages_i[i*WAY_W +: WAY_W] == WAY_W'(WAYS - 1)) begin
                victim_o = WAY_W'(i);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        ages_next_o = ages_i;
        age_w       = '0;
        old_age     = ages_i[int'(hit_way_i)*WAY_W +: WAY_W];
        for (int i = 0; i < WAYS; i++) begin
            age_w = ages_i[i*WAY_W +: WAY_W];
            if (WAY_W'(i) == hit_way_i) begin
                ages_next_o[i*WAY_W +: WAY_W] = '0;
            end else if (age_w < old_age) begin
                ages_next_o[i*WAY_W +: WAY_W] = age_w + WAY_W'(1);
            end
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-through, no-write-allocate set-associative cache with a word-serial
// block fill from a simple acknowledged memory port.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WAYS       = DEF_WAYS,
    parameter int SETS       = DEF_SETS,
    parameter int WORDS      = DEF_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  miss_detected,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int WORD_W = $clog2(WORDS);
    localparam int OFF_W  = WORD_W + 1;
    localparam int SET_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - SET_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_e                state_q, state_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0]     cnt_q, cnt_d;
    logic [WAY_W-1:0]      victim_q, victim_d;

    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS*WAY_W-1:0] age_q   [SETS];
    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS][WORDS];

    logic [WORD_W-1:0]     word_idx;
    logic [SET_W-1:0]      set_idx;
    logic [TAG_W-1:0]      tag_in;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [DATA_WIDTH-1:0] hit_word;
    logic [WAY_W-1:0]      victim;
    logic [WAYS*WAY_W-1:0] ages_next;
    logic                  age_upd, fill_start, fill_we, fill_done, wr_hit_we;

    assign word_idx = addr_q[OFF_W-1:1];
    assign set_idx  = addr_q[OFF_W+SET_W-1:OFF_W];
    assign tag_in   = addr_q[ADDR_WIDTH-1:OFF_W+SET_W];
    assign hit_word = data_q[set_idx][hit_way][word_idx];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    cache_way_lru #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_lru (
        .ages_i      (age_q[set_idx]),
        .valid_i     (valid_q[set_idx]),
        .hit_way_i   (hit_way),
        .victim_o    (victim),
        .ages_next_o (ages_next)
    );

    always_comb begin
        state_d       = state_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        victim_d      = victim_q;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rdata     = '0;
        miss_detected = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        age_upd       = 1'b0;
        fill_start    = 1'b0;
        fill_we       = 1'b0;
        fill_done     = 1'b0;
        wr_hit_we     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (wr_q) begin
                    wr_hit_we = hit;
                    age_upd   = hit;
                    state_d   = WRITE_MEM;
                end else if (hit) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = hit_word;
                    age_upd   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    fill_start = 1'b1;
                    victim_d   = victim;
                    cnt_d      = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                miss_detected = 1'b1;
                mem_rd        = 1'b1;
                mem_addr      = {addr_q[ADDR_WIDTH-1:OFF_W], cnt_q, 1'b0};
                if (mem_ack) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + WORD_W'(1);
                    if (cnt_q == WORD_W'(WORDS - 1)) begin
                        fill_done = 1'b1;
                        state_d   = COMPARE;
                    end
                end
            end
            WRITE_MEM: begin
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    rsp_valid = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
        end
    end

    // Victim is invalidated up front so a half-filled block can never hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w*WAY_W +: WAY_W] <= WAY_W'(w);
                end
            end
        end else begin
            if (fill_start) valid_q[set_idx][victim] <= 1'b0;
            if (fill_done)  valid_q[set_idx][victim_q] <= 1'b1;
            if (age_upd)    age_q[set_idx] <= ages_next;
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (fill_done) tag_q[set_idx][victim_q] <= tag_in;
        if (fill_we)   data_q[set_idx][victim_q][cnt_q] <= mem_rdata;
        if (wr_hit_we) data_q[set_idx][hit_way][word_idx] <= wdata_q;
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: a word-addressed memory model answers
// fills and write-throughs with an alternating acknowledge.
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wr;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, miss_detected, mem_rd, mem_wr, mem_ack;
    logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        resp_ack, stray_ack;

    int          n_cmp = 0;
    int          n_err = 0;
    int          rd_total = 0;
    int          wr_total = 0;
    logic [15:0] rd_log [64];
    logic [15:0] wr_addr_last, wr_data_last;
    logic [15:0] model [32768];

    logic [15:0] t_rdata;
    int          t_lat, t_rd, t_wr;
    logic        t_miss;
    logic        both_ever = 1'b0;

    assign mem_ack = resp_ack | stray_ack;

    set_assoc_cache dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .miss_detected (miss_detected),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    // Memory: word at byte address a holds a ^ 0x5A5A until written.
    initial begin
        resp_ack  = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 32768; i++) model[i] = 16'(i * 2) ^ 16'h5A5A;
        forever begin
            @(negedge clk);
            if (!rst && !resp_ack && mem_rd) begin
                resp_ack  = 1'b1;
                mem_rdata = model[mem_addr[15:1]];
                rd_log[rd_total % 64] = mem_addr;
                rd_total++;
            end else if (!rst && !resp_ack && mem_wr) begin
                resp_ack = 1'b1;
                model[mem_addr[15:1]] = mem_wdata;
                wr_addr_last = mem_addr;
                wr_data_last = mem_wdata;
                wr_total++;
            end else begin
                resp_ack  = 1'b0;
                mem_rdata = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic txn(input logic wr, input logic [15:0] a, input logic [15:0] d);
        int   rd0, wr0;
        logic done;
        rd0 = rd_total; wr0 = wr_total;
        t_miss = 1'b0; t_rdata = '0; t_lat = 0; done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        #2 check("req_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (!done && t_lat < 200) begin
            @(negedge clk);
            #2;
            t_lat++;
            if (miss_detected) t_miss = 1'b1;
            if (mem_rd && mem_wr) both_ever = 1'b1;
            if (rsp_valid) begin
                done    = 1'b1;
                t_rdata = rsp_rdata;
            end
        end
        check("rsp_seen", done, 1);
        @(negedge clk);
        #2 check("rsp_pulse", rsp_valid, 0);
        t_rd = rd_total - rd0;
        t_wr = wr_total - wr0;
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a, input logic [15:0] exp_data,
                          input int exp_rd);
        txn(1'b0, a, 16'h0);
        check({nm, "_data"}, t_rdata, exp_data);
        check({nm, "_memrd"}, t_rd, exp_rd);
        check({nm, "_miss"}, t_miss, exp_rd != 0);
        check({nm, "_nowr"}, t_wr, 0);
        if (exp_rd == 0) check({nm, "_lat"}, t_lat, 1);
    endtask

    task automatic wr_chk(input string nm, input logic [15:0] a, input logic [15:0] d);
        txn(1'b1, a, d);
        check({nm, "_memwr"}, t_wr, 1);
        check({nm, "_nord"}, t_rd, 0);
        check({nm, "_addr"}, wr_addr_last, a);
        check({nm, "_wdata"}, wr_data_last, d);
        check({nm, "_miss"}, t_miss, 0);
    endtask

    initial begin
        int          rd0, guard;
        logic        rsp_err;
        logic [52:0] snap;
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        stray_ack = 1'b0;
        #3;
        check("rst_ctl", {req_ready, rsp_valid, miss_detected, mem_rd, mem_wr}, 5'b0);
        check("rst_data", {mem_addr, mem_wdata, rsp_rdata}, 48'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2 check("ready_after_rst", req_ready, 1);

        // Cold read miss, fill order, then hit.
        rd_chk("cold", 16'h1234, 16'h486E, 8);
        for (int i = 0; i < 8; i++)
            check("fill_addr", rd_log[(rd_total - 8 + i) % 64], 16'h1230 + 16'(2 * i));
        rd_chk("rehit", 16'h1234, 16'h486E, 0);

        // Write hit goes through to memory and updates the cached word.
        wr_chk("wr_hit", 16'h1236, 16'hBEEF);
        rd_chk("wr_hit_rd", 16'h1236, 16'hBEEF, 0);
        rd_chk("wr_neigh", 16'h1234, 16'h486E, 0);

        // Write miss does not allocate.
        wr_chk("wr_miss", 16'h8000, 16'h0001);
        rd_chk("wr_miss_rd", 16'h8000, 16'h0001, 8);

        // Two-way replacement in set 1.
        rd_chk("lru_a", 16'h0010, 16'h5A4A, 8);
        rd_chk("lru_b", 16'h0410, 16'h5E4A, 8);
        rd_chk("lru_a2", 16'h0010, 16'h5A4A, 0);
        rd_chk("lru_c", 16'h0810, 16'h524A, 8);
        rd_chk("lru_a3", 16'h0010, 16'h5A4A, 0);
        rd_chk("lru_b2", 16'h0410, 16'h5E4A, 8);

        // Reset during a fill abandons it.
        rd0 = rd_total; guard = 0; rsp_err = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h2234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (rd_total - rd0 < 3 && guard < 100) begin
            @(negedge clk);
            #2;
            guard++;
            if (rsp_valid) rsp_err = 1'b1;
        end
        check("fill3_reached", rd_total - rd0, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ctl", {req_ready, rsp_valid, miss_detected, mem_rd, mem_wr}, 5'b0);
        check("midrst_data", {mem_addr, mem_wdata, rsp_rdata}, 48'h0);
        check("midrst_norsp", rsp_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2 check("post_rst_idle", {rsp_valid, mem_rd}, 2'b0);
        rd_chk("refill", 16'h1234, 16'h486E, 8);

        // Stray acknowledge while idle.
        @(negedge clk);
        #2 snap = {req_ready, rsp_valid, miss_detected, mem_rd, mem_wr, mem_addr, mem_wdata, rsp_rdata};
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        #2 check("stray_out", {req_ready, rsp_valid, miss_detected, mem_rd, mem_wr,
                               mem_addr, mem_wdata, rsp_rdata}, snap);
        rd_chk("stray_hit", 16'h1234, 16'h486E, 0);

        check("rd_wr_exclusive", both_ever, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
